// File: rtl/mem_lsu.sv
// Load/store unit: one byte/half/word access at a time to a word-addressed memory.
// Sub-word stores are done as read-modify-write; misaligned requests never reach memory.
module mem_lsu (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req_valid,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_busy,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_misaligned,
  output logic [31:0] o_memAddr,
  output logic [31:0] o_writeData,
  output logic [1:0]  o_ctrlMEM,
  input  logic [31:0] i_readData
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;

  state_t      state_r, state_next_s;
  logic        we_r, uns_r, mis_r;
  logic [1:0]  size_r, lane_r;
  logic [31:0] wdata_r, mem_addr_r, write_data_r, rdata_r;
  logic        req_mis_s, req_word_s;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] low);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = low[0];
      default: mis = (low != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00:   r[{lane, 3'b000} +: 8] = wdata[7:0];
      2'b01:   r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

  assign req_mis_s  = is_misaligned(i_req_size, i_req_addr[1:0]);
  assign req_word_s = i_req_size[1];

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!i_req_valid) begin
          state_next_s = IDLE;
        end else if (req_mis_s) begin
          state_next_s = RESP;
        end else if (i_req_we && req_word_s) begin
          state_next_s = WRITE;
        end else begin
          state_next_s = READ;
        end
      end
      READ: begin
        if (we_r) begin
          state_next_s = WRITE;
        end else begin
          state_next_s = RESP;
        end
      end
      WRITE:   state_next_s = RESP;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State and datapath registers; memory address only moves for accesses that reach memory
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r      <= IDLE;
      we_r         <= 1'b0;
      uns_r        <= 1'b0;
      mis_r        <= 1'b0;
      size_r       <= 2'b00;
      lane_r       <= 2'b00;
      wdata_r      <= 32'h00000000;
      mem_addr_r   <= 32'h00000000;
      write_data_r <= 32'h00000000;
      rdata_r      <= 32'h00000000;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        IDLE: begin
          if (i_req_valid) begin
            we_r    <= i_req_we;
            uns_r   <= i_req_unsigned;
            size_r  <= i_req_size;
            lane_r  <= i_req_addr[1:0];
            wdata_r <= i_req_wdata;
            mis_r   <= req_mis_s;
            rdata_r <= 32'h00000000;
            if (!req_mis_s) begin
              mem_addr_r <= {i_req_addr[31:2], 2'b00};
              if (i_req_we && req_word_s) begin
                write_data_r <= i_req_wdata;
              end
            end
          end
        end
        READ: begin
          if (we_r) begin
            write_data_r <= store_merge(i_readData, size_r, lane_r, wdata_r);
          end else begin
            rdata_r <= load_extract(i_readData, size_r, lane_r, uns_r);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy       = (state_r != IDLE);
  assign o_resp_valid = (state_r == RESP);
  assign o_resp_rdata = (state_r == RESP) ? rdata_r : 32'h00000000;
  assign o_misaligned = (state_r == RESP) & mis_r;
  assign o_memAddr    = mem_addr_r;
  assign o_writeData  = write_data_r;
  assign o_ctrlMEM    = (state_r == READ) ? 2'b10 : ((state_r == WRITE) ? 2'b01 : 2'b00);

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: vector table of loads/stores against a small word memory,
// plus reset sequences (idle, after traffic, and during the write phase of a byte store).
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        busy, resp_valid, misaligned;
  logic [31:0] resp_rdata, mem_addr, write_data;
  logic [1:0]  ctrl;
  logic [31:0] read_data = 32'h0;
  logic [31:0] mem [0:255];

  int tests = 0;
  int failed = 0;

  mem_lsu dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_req_valid(req_valid), .i_req_we(req_we),
    .i_req_size(req_size), .i_req_unsigned(req_uns), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_busy(busy), .o_resp_valid(resp_valid),
    .o_resp_rdata(resp_rdata), .o_misaligned(misaligned), .o_memAddr(mem_addr),
    .o_writeData(write_data), .o_ctrlMEM(ctrl), .i_readData(read_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ctrl == 2'b10) read_data <= mem[mem_addr[9:2]];
  always @(posedge clk) if (ctrl == 2'b01) mem[mem_addr[9:2]] <= write_data;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_mis;
    int          exp_lat;
    int          exp_nrd;
    int          exp_nwr;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] exp_rd, input logic exp_mis, input int exp_lat,
                              input int exp_nrd, input int exp_nwr, input logic [31:0] exp_wd);
    vec_t v;
    v.we = we; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd;
    v.exp_rd = exp_rd; v.exp_mis = exp_mis; v.exp_lat = exp_lat;
    v.exp_nrd = exp_nrd; v.exp_nwr = exp_nwr; v.exp_wd = exp_wd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_busy"}, {31'h0, busy}, 32'h0);
    chk({nm, "_resp_valid"}, {31'h0, resp_valid}, 32'h0);
    chk({nm, "_rdata"}, resp_rdata, 32'h0);
    chk({nm, "_mis"}, {31'h0, misaligned}, 32'h0);
    chk({nm, "_memaddr"}, mem_addr, 32'h0);
    chk({nm, "_wdata"}, write_data, 32'h0);
    chk({nm, "_ctrl"}, {30'h0, ctrl}, 32'h0);
  endtask

  task automatic do_req(input vec_t v, input string nm);
    int cyc, nrd, nwr;
    logic [31:0] wdv;
    logic bad_addr, bad_ctrl;
    nrd = 0; nwr = 0; wdv = 32'h0; bad_addr = 1'b0; bad_ctrl = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_size = v.sz; req_uns = v.uns;
    req_addr = v.addr; req_wdata = v.wd;
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
    req_we = ~v.we; req_size = 2'b11; req_uns = ~v.uns;
    cyc = 1;
    chk({nm, "_busy"}, {31'h0, busy}, 32'h1);
    while (resp_valid !== 1'b1 && cyc < 12) begin
      if (ctrl == 2'b01) begin nwr++; wdv = write_data; end
      if (ctrl == 2'b10) nrd++;
      if (ctrl == 2'b11) bad_ctrl = 1'b1;
      if (ctrl != 2'b00 && mem_addr !== {v.addr[31:2], 2'b00}) bad_addr = 1'b1;
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_latency"}, 32'(cyc), 32'(v.exp_lat));
    chk({nm, "_rdata"}, resp_rdata, v.exp_rd);
    chk({nm, "_mis"}, {31'h0, misaligned}, {31'h0, v.exp_mis});
    chk({nm, "_ctrl_resp"}, {30'h0, ctrl}, 32'h0);
    chk({nm, "_nread"}, 32'(nrd), 32'(v.exp_nrd));
    chk({nm, "_nwrite"}, 32'(nwr), 32'(v.exp_nwr));
    chk({nm, "_ctrl11"}, {31'h0, bad_ctrl}, 32'h0);
    chk({nm, "_memaddr"}, {31'h0, bad_addr}, 32'h0);
    if (v.exp_nwr > 0) chk({nm, "_wword"}, wdv, v.exp_wd);
    @(negedge clk);
    chk({nm, "_idle_valid"}, {31'h0, resp_valid}, 32'h0);
    chk({nm, "_idle_busy"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    vq.push_back(mk(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 32'hDEADBEEF));
    vq.push_back(mk(1'b1, 2'b10, 1'b0, 32'h104, 32'h80FF7F01, 32'h0, 1'b0, 2, 0, 1, 32'h80FF7F01));
    vq.push_back(mk(1'b0, 2'b00, 1'b0, 32'h107, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1, 0, 32'h0));
    vq.push_back(mk(1'b0, 2'b00, 1'b1, 32'h107, 32'h0, 32'h00000080, 1'b0, 2, 1, 0, 32'h0));
    vq.push_back(mk(1'b0, 2'b01, 1'b0, 32'h106, 32'h0, 32'hFFFF80FF, 1'b0, 2, 1, 0, 32'h0));
    vq.push_back(mk(1'b0, 2'b01, 1'b1, 32'h104, 32'h0, 32'h00007F01, 1'b0, 2, 1, 0, 32'h0));
    vq.push_back(mk(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'h80FF7F01, 1'b0, 2, 1, 0, 32'h0));
    vq.push_back(mk(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0));
    vq.push_back(mk(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h0000DEAD, 1'b0, 2, 1, 0, 32'h0));
    vq.push_back(mk(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFFDEAD, 1'b0, 2, 1, 0, 32'h0));
    vq.push_back(mk(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'hFFFFFFEF, 1'b0, 2, 1, 0, 32'h0));
    vq.push_back(mk(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h000000BE, 1'b0, 2, 1, 0, 32'h0));
    vq.push_back(mk(1'b1, 2'b10, 1'b0, 32'h104, 32'h11223344, 32'h0, 1'b0, 2, 0, 1, 32'h11223344));
    vq.push_back(mk(1'b1, 2'b00, 1'b0, 32'h105, 32'h000000AA, 32'h0, 1'b0, 3, 1, 1, 32'h1122AA44));
    vq.push_back(mk(1'b1, 2'b01, 1'b0, 32'h106, 32'h0000BEEF, 32'h0, 1'b0, 3, 1, 1, 32'hBEEFAA44));
    vq.push_back(mk(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'hBEEFAA44, 1'b0, 2, 1, 0, 32'h0));
    vq.push_back(mk(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0));
    vq.push_back(mk(1'b1, 2'b01, 1'b0, 32'h101, 32'h1234, 32'h0, 1'b1, 1, 0, 0, 32'h0));
    vq.push_back(mk(1'b1, 2'b10, 1'b0, 32'h106, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 0, 32'h0));
    vq.push_back(mk(1'b0, 2'b01, 1'b1, 32'h103, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0));
    vq.push_back(mk(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0));
    vq.push_back(mk(1'b1, 2'b00, 1'b1, 32'h100, 32'h000001FF, 32'h0, 1'b0, 3, 1, 1, 32'hDEADBEFF));
    vq.push_back(mk(1'b1, 2'b00, 1'b0, 32'h107, 32'h0000005A, 32'h0, 1'b0, 3, 1, 1, 32'h5AEFAA44));
    vq.push_back(mk(1'b0, 2'b00, 1'b0, 32'h105, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 1, 0, 32'h0));
    vq.push_back(mk(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEFF, 1'b0, 2, 1, 0, 32'h0));

    // Reset from power-up, then released while idle
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("por_rel");

    for (int i = 0; i < vq.size(); i++) do_req(vq[i], $sformatf("vec%0d", i));

    // Reset after traffic, while idle
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("idle_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during the write phase of a byte store: the RMW write must be dropped
    do_req(mk(1'b1, 2'b10, 1'b0, 32'h110, 32'h11223344, 32'h0, 1'b0, 2, 0, 1, 32'h11223344), "pre_sw");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_uns = 1'b0;
    req_addr = 32'h111; req_wdata = 32'h77;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rmw_read_ctrl", {30'h0, ctrl}, 32'h2);
    @(negedge clk);
    chk("rmw_write_ctrl", {30'h0, ctrl}, 32'h1);
    chk("rmw_write_word", write_data, 32'h11227744);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmw_rst_ctrl", {30'h0, ctrl}, 32'h0);
    chk("rmw_rst_busy", {31'h0, busy}, 32'h0);
    chk("rmw_rst_valid", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rmw_rst_mem", mem[8'h44], 32'h11223344);
    do_req(mk(1'b0, 2'b10, 1'b0, 32'h110, 32'h0, 32'h11223344, 1'b0, 2, 1, 0, 32'h0), "post_lw");
    do_req(mk(1'b1, 2'b00, 1'b0, 32'h111, 32'h77, 32'h0, 1'b0, 3, 1, 1, 32'h11227744), "post_sb");
    do_req(mk(1'b0, 2'b10, 1'b0, 32'h110, 32'h0, 32'h11227744, 1'b0, 2, 1, 0, 32'h0), "post_lw2");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
